// File: rtl/sr_pkg.sv
// sr_pkg: shared opcode/state encodings and defaults for the SR flip-flop driver
package sr_pkg;
    localparam int HOLD_CYCLES_DEF = 5;
    typedef enum logic [1:0] {OP_HOLD = 2'b00, OP_SET = 2'b01, OP_RESET = 2'b10, OP_TOGGLE = 2'b11} op_t;
    typedef enum logic [1:0] {IDLE = 2'b00, DRIVE = 2'b01, CHECK = 2'b10} state_t;
    function automatic logic exp_of(input op_t op, input logic q0);
        return op == OP_SET ? 1'b1 : op == OP_RESET ? 1'b0 : op == OP_HOLD ? q0 : ~q0;
    endfunction
endpackage

// File: rtl/sr_hold_cnt.sv
// sr_hold_cnt: loadable down-counter with zero flag timing the drive interval
module sr_hold_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (en) cnt <= cnt - 1'b1;
    end
    assign zero = cnt == '0;
endmodule

// File: rtl/sr_driver.sv
// sr_driver: drives an external SR flip-flop for a programmed length, then checks q_fb
module sr_driver
    import sr_pkg::*;
#(
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] hold_len,
    output logic             S,
    output logic             R,
    input  logic             q_fb,
    output logic             done,
    output logic             mismatch,
    output logic [CNT_W-1:0] err_cnt
);
    localparam logic [CNT_W-1:0] DEF_M1 = CNT_W'(HOLD_CYCLES - 1);
    state_t           state;
    op_t              op_q;
    logic             q0;
    logic             zero;
    logic             accept;
    logic             miss;
    logic [CNT_W-1:0] len_m1;
    op_t              op_in;
    assign op_in     = op_t'(cmd_op);
    assign cmd_ready = state == IDLE;
    assign accept    = cmd_valid & cmd_ready;
    assign len_m1    = hold_len == '0 ? DEF_M1 : hold_len - 1'b1;
    assign miss      = q_fb != exp_of(op_q, q0);
    sr_hold_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (len_m1),
        .en       (state == DRIVE && !zero),
        .zero     (zero)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            op_q     <= OP_HOLD;
            q0       <= 1'b0;
            S        <= 1'b0;
            R        <= 1'b0;
            done     <= 1'b0;
            mismatch <= 1'b0;
            err_cnt  <= '0;
        end else begin
            done     <= 1'b0;
            mismatch <= 1'b0;
            case (state)
                IDLE: if (cmd_valid) begin
                    state <= DRIVE;
                    op_q  <= op_in;
                    q0    <= q_fb;
                    S     <= op_in == OP_SET || (op_in == OP_TOGGLE && !q_fb);
                    R     <= op_in == OP_RESET || (op_in == OP_TOGGLE && q_fb);
                end
                DRIVE: if (zero) begin
                    state <= CHECK;
                    S     <= 1'b0;
                    R     <= 1'b0;
                end
                CHECK: begin
                    state    <= IDLE;
                    done     <= 1'b1;
                    mismatch <= miss;
                    if (miss && !(&err_cnt)) err_cnt <= err_cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sr_driver.sv
// tb_sr_driver: directed bench with SR flip-flop plant and cycle-level behavioural model
module tb_sr_driver;
    import sr_pkg::*;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] hold_len = 8'd0;
    logic       S, R, q_fb, done, mismatch;
    logic [7:0] err_cnt;
    logic       q_ff = 1'b0;
    logic       force0 = 1'b0;
    logic       on = 1'b0;
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         m_ph = 0, m_n = 0, m_err = 0;
    logic       m_s = 0, m_r = 0, m_exp = 0, m_done = 0, m_mis = 0;
    logic       e_rdy, e_s, e_r;

    sr_driver dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .hold_len(hold_len), .S(S), .R(R), .q_fb(q_fb),
        .done(done), .mismatch(mismatch), .err_cnt(err_cnt)
    );

    always #10 clk = ~clk;

    always @(posedge clk) begin
        q_ff <= S ? 1'b1 : R ? 1'b0 : q_ff;
        cyc  <= cyc + 1;
    end
    assign q_fb = force0 ? 1'b0 : q_ff;

    always @(posedge clk) begin
        if (rst) begin
            m_ph = 0; m_done = 0; m_mis = 0; m_err = 0;
        end else begin
            m_done = 0; m_mis = 0;
            if (m_ph == 0) begin
                if (cmd_valid) begin
                    m_n = hold_len == 0 ? 5 : int'(hold_len);
                    case (cmd_op)
                        2'b01:   begin m_s = 1; m_r = 0; m_exp = 1; end
                        2'b10:   begin m_s = 0; m_r = 1; m_exp = 0; end
                        2'b00:   begin m_s = 0; m_r = 0; m_exp = q_fb; end
                        default: begin m_s = !q_fb; m_r = q_fb; m_exp = !q_fb; end
                    endcase
                    m_ph = 1;
                end
            end else if (m_ph <= m_n) m_ph = m_ph + 1;
            else begin
                m_done = 1;
                m_mis  = q_fb != m_exp;
                if (m_mis && m_err < 255) m_err = m_err + 1;
                m_ph = 0;
            end
        end
    end

    assign e_rdy = m_ph == 0;
    assign e_s   = m_ph >= 1 && m_ph <= m_n && m_s;
    assign e_r   = m_ph >= 1 && m_ph <= m_n && m_r;

    always @(negedge clk) if (on) begin
        total++;
        if (cmd_ready !== e_rdy || S !== e_s || R !== e_r || done !== m_done ||
            mismatch !== m_mis || err_cnt !== 8'(m_err)) begin
            bad++;
            $display("FAIL model cyc=%0d rdy=%b/%b S=%b/%b R=%b/%b done=%b/%b mis=%b/%b err=%0d/%0d",
                     cyc, cmd_ready, e_rdy, S, e_s, R, e_r, done, m_done, mismatch, m_mis, err_cnt, m_err);
        end
        total++;
        if (S & R) begin
            bad++;
            $display("FAIL sr_overlap cyc=%0d S=%b R=%b required not both 1", cyc, S, R);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic run(input logic [1:0] op, input logic [7:0] len,
                       output int s_cyc, output int r_cyc, output int lat, output int mis);
        int k;
        k = 0;
        while (!cmd_ready && k < 1000) begin @(negedge clk); k++; end
        chk("ready_wait", int'(k >= 1000), 0);
        cmd_valid = 1; cmd_op = op; hold_len = len;
        @(negedge clk);
        cmd_valid = 0;
        s_cyc = 0; r_cyc = 0; k = 0;
        while (!done && k < 600) begin
            s_cyc += int'(S); r_cyc += int'(R);
            @(negedge clk); k++;
        end
        chk("done_wait", int'(k >= 600), 0);
        lat = k;
        mis = int'(mismatch);
    endtask

    initial begin
        int s_c, r_c, lat, mis, acc, last, dn;
        logic flip;
        repeat (3) @(negedge clk);
        on = 1;
        rst = 0;
        @(negedge clk);
        chk("rst_ready", int'(cmd_ready), 1);
        chk("rst_sr", int'({S, R}), 0);
        chk("rst_err", int'(err_cnt), 0);

        run(OP_SET, 8'd0, s_c, r_c, lat, mis);
        chk("set_s_cycles", s_c, 5); chk("set_r_cycles", r_c, 0);
        chk("set_latency", lat, 6); chk("set_mis", mis, 0); chk("set_q", int'(q_fb), 1);

        run(OP_RESET, 8'd3, s_c, r_c, lat, mis);
        chk("rst_r_cycles", r_c, 3); chk("rst_s_cycles", s_c, 0);
        chk("rst_latency", lat, 4); chk("rst_mis", mis, 0);
        chk("rst_q", int'(q_fb), 0); chk("rst_errcnt", int'(err_cnt), 0);

        run(OP_TOGGLE, 8'd2, s_c, r_c, lat, mis);
        chk("tog1_s", s_c, 2); chk("tog1_r", r_c, 0); chk("tog1_q", int'(q_fb), 1); chk("tog1_mis", mis, 0);
        run(OP_TOGGLE, 8'd2, s_c, r_c, lat, mis);
        chk("tog2_r", r_c, 2); chk("tog2_s", s_c, 0); chk("tog2_q", int'(q_fb), 0); chk("tog2_mis", mis, 0);

        run(OP_HOLD, 8'd1, s_c, r_c, lat, mis);
        chk("hold_sr", s_c + r_c, 0); chk("hold_mis", mis, 0); chk("hold_latency", lat, 2);

        force0 = 1;
        run(OP_SET, 8'd1, s_c, r_c, lat, mis);
        chk("force_mis", mis, 1);
        @(negedge clk);
        chk("force_err1", int'(err_cnt), 1);
        for (int i = 0; i < 299; i++) run(OP_SET, 8'd1, s_c, r_c, lat, mis);
        @(negedge clk);
        chk("force_err_sat", int'(err_cnt), 255);
        force0 = 0;

        flip = 0; acc = 0; last = -1; dn = 0;
        cmd_valid = 1; cmd_op = OP_SET; hold_len = 8'd1;
        for (int i = 0; i < 15; i++) begin
            if (cmd_ready) begin
                if (last >= 0) chk("b2b_period", i - last, 3);
                last = i; acc++; flip = 1;
            end else if (flip) begin
                cmd_op = cmd_op == OP_SET ? OP_RESET : OP_SET;
                flip = 0;
            end
            dn += int'(done & mismatch);
            @(negedge clk);
        end
        cmd_valid = 0;
        chk("b2b_accepts", acc, 5);
        chk("b2b_no_mis", dn, 0);
        repeat (4) @(negedge clk);

        cmd_valid = 1; cmd_op = OP_SET; hold_len = 8'd5;
        @(negedge clk);
        cmd_valid = 0;
        chk("abort_drive1_s", int'(S), 1);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        chk("abort_s", int'(S), 0);
        rst = 0;
        @(negedge clk);
        chk("abort_ready", int'(cmd_ready), 1);
        chk("abort_err", int'(err_cnt), 0);
        dn = 0;
        for (int i = 0; i < 10; i++) begin dn += int'(done); @(negedge clk); end
        chk("abort_no_done", dn, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sr_driver.md
SR_DRIVER -- requirements
Module: sr_driver

Interface
REQ-001 Parameter: HOLD_CYCLES, default 5, S/R drive length in clk cycles used when hold_len is 0; legal range 1..255.
REQ-002 Parameter: CNT_W, default 8, width of hold_len, the hold counter and err_cnt.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 cmd_valid  input  1  command present.
REQ-006 cmd_ready  output  1  driver idle and able to accept a command.
REQ-007 cmd_op  input  2  00 HOLD, 01 SET, 10 RESET, 11 TOGGLE.
REQ-008 hold_len  input  CNT_W  drive length in cycles; 0 selects HOLD_CYCLES.
REQ-009 S  output  1  set drive to the external SR flip-flop, registered.
REQ-010 R  output  1  reset drive to the external SR flip-flop, registered.
REQ-011 q_fb  input  1  q output of the driven flip-flop.
REQ-012 done  output  1  one-cycle pulse marking command completion.
REQ-013 mismatch  output  1  valid only with done; 1 means q_fb differed from the expected value.
REQ-014 err_cnt  output  CNT_W  count of mismatches, saturating at all-ones.

Function
REQ-015 FSM states: IDLE, DRIVE, CHECK. cmd_ready SHALL equal (state==IDLE).
REQ-016 Accept SHALL occur on an edge where cmd_valid & cmd_ready are both 1.
- cmd_op and the effective length N are latched at accept.
- expected_q and the S/R pair are latched at accept.
REQ-017 Drive values SHALL be set per command:
- SET: S=1, R=0; expected 1.
- RESET: S=0, R=1; expected 0.
- HOLD: S=0, R=0; expected q_fb at accept.
- TOGGLE: S=~q_fb, R=q_fb, both sampled at accept; expected ~q_fb at accept.
REQ-018 S and R SHALL never both be 1 in any cycle, including during and after reset.
REQ-019 For an accept at edge E0, S/R SHALL hold the latched pair from after E0 through edge EN, which is exactly N cycles; state is DRIVE over this interval.
REQ-020 After EN, state SHALL be CHECK for one cycle, with S=R=0.
REQ-021 At edge E(N+1), q_fb SHALL be compared with expected_q.
- done=1 and mismatch are registered for exactly one cycle.
- state returns to IDLE.
REQ-022 The cycle in which done=1 SHALL also have cmd_ready=1, so back-to-back commands lose no cycle.
REQ-023 cmd_valid, cmd_op and hold_len SHALL be ignored outside IDLE; commands are never queued.
REQ-024 On a mismatch, err_cnt SHALL increment by 1 at E(N+1) and stick at 2^CNT_W-1.
REQ-025 done and mismatch SHALL be 0 in all cycles other than the completion cycle.

Reset
REQ-026 On a clk edge with rst=1, the block SHALL enter IDLE and clear S, R, done, mismatch, err_cnt, the hold counter and all latched command state.
REQ-027 rst SHALL override any in-flight command; S/R drop to 0 after that edge and no done pulse is produced for the aborted command.
REQ-028 cmd_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-029 Shared package sr_pkg SHALL hold:
- the cmd_op encodings (OP_HOLD, OP_SET, OP_RESET, OP_TOGGLE);
- the FSM state encoding;
- the default HOLD_CYCLES constant.
REQ-030 Sub-module sr_hold_cnt SHALL contain the down-counter.
- inputs: load, load value N, enable.
- output: zero flag.
- one instance only.

Verification
REQ-031 The bench SHALL cover these scenarios; each runs against a behavioural SR flip-flop model on q_fb, with a 20 ns clk:
- Reset, then SET with hold_len=0 -> S=1, R=0 for exactly 5 cycles; done one cycle later; mismatch=0; q=1.
- RESET with hold_len=3 after SET -> R=1 for 3 cycles; q=0; done with mismatch=0; err_cnt stays 0.
- TOGGLE with q=0, then TOGGLE again -> first drives S=1 and q ends at 1; second drives R=1 and q ends at 0; both report mismatch=0.
- SET with q_fb forced to 0 -> done with mismatch=1; err_cnt 0->1. Repeating 300 times leaves err_cnt=255.
- cmd_valid held high continuously with alternating SET/RESET, hold_len=1 -> accept on every done cycle; period 3 cycles.
- rst asserted on the 2nd DRIVE cycle of a SET -> S=0 after that edge; no done; cmd_ready=1 after rst falls. A checker asserts S&R==0 in every cycle of every test.
